// File: rtl/rap_pkg.sv
// ----------------------------------------------------------------------------
// rap_pkg
// Shared definitions for the rapNN_k approximate-adder controller family.
//   RAP_W   : operand width of the rap16 adders
//   state_t : controller state encoding (IDLE/EVAL/FIX/DONE)
//   mode_t  : accuracy-mode encoding sampled with each operand pair
// ----------------------------------------------------------------------------
package rap_pkg;

    localparam int unsigned RAP_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EVAL = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MODE_APPROX  = 2'b00,
        MODE_CORRECT = 2'b01,
        MODE_EXACT   = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

endpackage

// File: rtl/rap16_2.sv
// ----------------------------------------------------------------------------
// rap16_2
// 16-bit approximate adder. The carry into each bit is built from only the
// three generate terms directly below it; longer propagate chains are cut.
//   a, b : operands
//   sum  : 17-bit approximate sum (bit 16 is the approximate carry out)
// ----------------------------------------------------------------------------
module rap16_2 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [16:0] sum
);

    logic [15:0] g;
    logic [15:0] p;
    logic [17:0] gx;   // g shifted up by two, zero padded below bit 0
    logic [17:0] px;
    logic [16:0] c;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gx = {g, 2'b00};
        px = {p, 2'b00};
        c  = '0;
        // gx[i+1] = g[i-1], gx[i] = g[i-2], gx[i-1] = g[i-3]
        for (int unsigned i = 1; i <= 16; i++) begin
            c[i] = gx[i+1]
                 | (px[i+1] & gx[i])
                 | (px[i+1] & px[i] & gx[i-1]);
        end
        sum = {c[16], p ^ c[15:0]};
    end

endmodule

// File: rtl/rap_err_det.sv
// ----------------------------------------------------------------------------
// rap_err_det
// Conservative error detector for the rap16_2 approximate adder. Fires when
// three adjacent propagate bits line up, which is the only situation in which
// the truncated lookahead can lose a carry term.
//   a, b : operands (RAP_W bits)
//   det  : 1 = approximate sum may differ from the exact sum
// ----------------------------------------------------------------------------
module rap_err_det
    import rap_pkg::*;
(
    input  logic [RAP_W-1:0] a,
    input  logic [RAP_W-1:0] b,
    output logic             det
);

    logic [RAP_W-1:0] p;

    always_comb begin
        p   = a ^ b;
        det = 1'b0;
        for (int unsigned i = 3; i < RAP_W; i++) begin
            det = det | (p[i] & p[i-1] & p[i-2]);
        end
    end

endmodule

// File: rtl/rap16_vl_ctrl.sv
// ----------------------------------------------------------------------------
// rap16_vl_ctrl
// Variable-latency controller around rap16_2. Registers one operand pair per
// transaction, evaluates the approximate sum, and depending on mode either
// returns it (flagging a possible error) or spends one extra cycle on an exact
// add. Keeps saturating completed/corrected transaction counters.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake, a/b/mode sampled on accept
//   a, b, mode          : operands and accuracy mode (11 behaves as 01)
//   out_valid/out_ready : result handshake
//   sum, err_flag       : result and approximate-and-detected flag
//   cnt_clr             : synchronous clear of both counters (wins over +1)
//   op_cnt, fix_cnt     : completed / corrected transaction counts
// ----------------------------------------------------------------------------
module rap16_vl_ctrl
    import rap_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W:0]    sum,
    output logic          err_flag,
    input  logic          cnt_clr,
    output logic [CW-1:0] op_cnt,
    output logic [CW-1:0] fix_cnt
);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, b_q;
    mode_t         mode_q;
    logic [W:0]    sum_q;
    logic          err_q;
    logic          fix_q;
    logic [CW-1:0] op_cnt_q, fix_cnt_q;

    logic [W:0]    approx;
    logic [W:0]    exact;
    logic          det;
    logic          accept;
    logic          out_hs;

    rap16_2 u_add (
        .a   (a_q),
        .b   (b_q),
        .sum (approx)
    );

    rap_err_det u_det (
        .a   (a_q),
        .b   (b_q),
        .det (det)
    );

    assign exact  = {1'b0, a_q} + {1'b0, b_q};
    assign accept = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = EVAL;
            EVAL: begin
                if (mode_q == MODE_EXACT || (mode_q == MODE_CORRECT && det))
                    state_d = FIX;
                else
                    state_d = DONE;
            end
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Operand capture and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= MODE_APPROX;
            sum_q  <= '0;
            err_q  <= 1'b0;
            fix_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                // Reserved encoding folded to detect-and-correct at capture
                mode_q <= (mode_t'(mode) == MODE_RSVD) ? MODE_CORRECT : mode_t'(mode);
                fix_q  <= 1'b0;
            end
            if (state_q == EVAL && state_d == DONE) begin
                sum_q <= approx;
                err_q <= (mode_q == MODE_APPROX) & det;
            end
            if (state_q == FIX) begin
                sum_q <= exact;
                err_q <= 1'b0;
                fix_q <= 1'b1;
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt_q  <= '0;
            fix_cnt_q <= '0;
        end else if (cnt_clr) begin
            op_cnt_q  <= '0;
            fix_cnt_q <= '0;
        end else if (out_hs) begin
            if (op_cnt_q != '1)
                op_cnt_q <= op_cnt_q + CW'(1);
            if (fix_q && fix_cnt_q != '1)
                fix_cnt_q <= fix_cnt_q + CW'(1);
        end
    end

    assign sum      = sum_q;
    assign err_flag = err_q;
    assign op_cnt   = op_cnt_q;
    assign fix_cnt  = fix_cnt_q;

endmodule

// File: tb/tb_rap16_vl_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rap16_vl_ctrl
// Directed bench for rap16_vl_ctrl with CW=4 so counter saturation is reached
// quickly. Expected results come from an independent windowed-carry model and
// are queued at stimulus time, then popped when out_valid appears.
// ----------------------------------------------------------------------------
module tb_rap16_vl_ctrl;

    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   a;
    logic [15:0]   b;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [16:0]   sum;
    logic          err_flag;
    logic          cnt_clr;
    logic [CW-1:0] op_cnt;
    logic [CW-1:0] fix_cnt;

    always #5 clk = ~clk;

    rap16_vl_ctrl #(.W(16), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .err_flag  (err_flag),
        .cnt_clr   (cnt_clr),
        .op_cnt    (op_cnt),
        .fix_cnt   (fix_cnt)
    );

    typedef struct {
        logic [16:0] sum;
        logic        err;
        int          lat;
        logic        fix;
    } exp_t;

    exp_t sb[$];
    int   ncomp   = 0;
    int   nfail   = 0;
    int   exp_op  = 0;
    int   exp_fix = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncomp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: carry into bit i is the carry out of an exact add of the
    // (at most) three operand bits just below i, with zero carry-in.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic [1:0] m);
        exp_t        r;
        logic [16:0] ap;
        logic [15:0] p;
        logic        det;
        logic        fix;
        int unsigned xs, ys, lo, wd, cy;
        int unsigned xi, yi;
        logic [1:0]  me;
        xi  = int'(x);
        yi  = int'(y);
        p   = x ^ y;
        det = 1'b0;
        for (int i = 3; i < 16; i++)
            if (p[i] && p[i-1] && p[i-2]) det = 1'b1;
        ap = '0;
        for (int i = 0; i <= 16; i++) begin
            cy = 0;
            if (i > 0) begin
                lo = (i >= 3) ? i - 3 : 0;
                wd = i - lo;
                xs = (xi >> lo) & ((1 << wd) - 1);
                ys = (yi >> lo) & ((1 << wd) - 1);
                cy = ((xs + ys) >> wd) & 1;
            end
            if (i < 16) ap[i] = x[i] ^ y[i] ^ cy[0];
            else        ap[16] = cy[0];
        end
        me    = (m == 2'b11) ? 2'b01 : m;
        fix   = (me == 2'b10) || (me == 2'b01 && det);
        r.sum = fix ? 17'(xi + yi) : ap;
        r.err = (me == 2'b00) && det;
        r.lat = fix ? 2 : 1;
        r.fix = fix;
        return r;
    endfunction

    task automatic txn(input logic [15:0] ta, input logic [15:0] tb_, input logic [1:0] tm,
                       input int stall, input bit clr_hs);
        exp_t e;
        int   lat;
        sb.push_back(model(ta, tb_, tm));
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a         = ta;
        b         = tb_;
        mode      = tm;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        mode     = 2'($urandom);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            a = 16'($urandom);
            b = 16'($urandom);
        end
        e = sb.pop_front();
        check("latency", 32'(lat), 32'(e.lat));
        check("sum", 32'(sum), 32'(e.sum));
        check("err_flag", 32'(err_flag), 32'(e.err));
        check("op_cnt_hold", 32'(op_cnt), 32'(exp_op));
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("bp_sum", 32'(sum), 32'(e.sum));
            check("bp_err", 32'(err_flag), 32'(e.err));
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_op_cnt", 32'(op_cnt), 32'(exp_op));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = clr_hs;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        if (clr_hs) begin
            exp_op  = 0;
            exp_fix = 0;
        end else begin
            if (exp_op < CNTMAX) exp_op++;
            if (e.fix && exp_fix < CNTMAX) exp_fix++;
        end
        check("out_valid_after", 32'(out_valid), 32'd0);
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("op_cnt", 32'(op_cnt), 32'(exp_op));
        check("fix_cnt", 32'(fix_cnt), 32'(exp_fix));
        out_ready = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_err", 32'(err_flag), 32'd0);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
        check("rst_fix_cnt", 32'(fix_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        mode      = '0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        #2;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed patterns from the plan
        txn(16'h0001, 16'h0002, 2'b01, 0, 1'b0);
        txn(16'h00FF, 16'h0001, 2'b01, 0, 1'b0);
        txn(16'h00FF, 16'h0001, 2'b00, 0, 1'b0);
        txn(16'hFFFF, 16'hFFFF, 2'b10, 0, 1'b0);
        txn(16'hFFFF, 16'hFFFF, 2'b01, 0, 1'b0);
        txn(16'h1234, 16'h0F0F, 2'b11, 0, 1'b0);
        // Backpressure on both result paths
        txn(16'h00FF, 16'h0001, 2'b01, 5, 1'b0);
        txn(16'hAAAA, 16'h5555, 2'b00, 5, 1'b0);
        // Random operands and modes
        for (int i = 0; i < 4; i++)
            txn(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'b0);

        // Reset while in FIX
        a        = 16'h00FF;
        b        = 16'h0001;
        mode     = 2'b10;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("fix_out_valid", 32'(out_valid), 32'd0);
        check("fix_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check_reset_state();
        #2;
        rst     = 1'b0;
        exp_op  = 0;
        exp_fix = 0;
        @(posedge clk); #1;
        txn(16'h0F00, 16'h0100, 2'b01, 0, 1'b0);

        // Saturation of both counters
        for (int i = 0; i < 18; i++)
            txn(16'(i * 7), 16'(i * 3), 2'b10, 0, 1'b0);
        check("op_cnt_sat", 32'(op_cnt), 32'(CNTMAX));
        check("fix_cnt_sat", 32'(fix_cnt), 32'(CNTMAX));

        // Clear while idle, then clear coinciding with a completion
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        exp_op  = 0;
        exp_fix = 0;
        check("clr_op_cnt", 32'(op_cnt), 32'(exp_op));
        check("clr_fix_cnt", 32'(fix_cnt), 32'(exp_fix));
        txn(16'h0003, 16'h0004, 2'b00, 0, 1'b0);
        txn(16'h00FF, 16'h0001, 2'b10, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/rap16_vl_ctrl.md
# rap16_vl_ctrl

Variable-latency controller around the 16-bit approximate adder `rap16_2`. Accepts one operand pair per transaction. Detects when the adder's limited carry lookahead may have produced a wrong result, and, depending on mode, either corrects the result with an exact add in one extra cycle or flags it. It sits between an upstream operand source and a downstream result sink, both using valid/ready handshakes, and keeps accuracy statistics for the AxLEAP evaluation flow.

## Interface
Parameters:
- `W`, 16: operand width; fixed at 16 to match `rap16_2`.
- `CW`, 16: statistics counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: controller can accept an operand pair.
- `a`, `b` in 16: operands.
- `mode` in 2: accuracy mode, sampled at accept. `00` = approx-only, `01` = detect-and-correct, `10` = always exact, `11` = reserved, treated as `01`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: sink accepts the result.
- `sum` out 17: result.
- `err_flag` out 1: the result is approximate and the error detector fired.
- `cnt_clr` in 1: synchronous clear of both counters.
- `op_cnt` out CW: completed transactions, saturating.
- `fix_cnt` out CW: transactions that took the correction cycle, saturating.

## Operation
- **Operand capture.** Operands and mode are registered on accept: `in_valid & in_ready`.
- **Error detector (combinational, on the registered operands).**
  - p = a^b.
  - det = OR over i = 3..15 of p[i]&p[i-1]&p[i-2].
  - This is exactly the condition under which the lookahead drops a carry term. Detection is conservative: det=1 does not imply an actual mismatch.
- **State machine (IDLE, EVAL, FIX, DONE):**
  - IDLE: in_ready=1. Go to EVAL on accept.
  - EVAL, with the approximate sum from the `rap16_2` instance:
    - mode `00`: load sum_q ← approx, err_q ← det, go to DONE.
    - mode `01` with det=0: load sum_q ← approx, err_q ← 0, go to DONE.
    - mode `01` with det=1, or mode `10`: go to FIX.
  - FIX: load sum_q ← exact a+b (17-bit), err_q ← 0, set the fix flag, go to DONE.
  - DONE: out_valid=1. On out_ready go to IDLE and update counters.
- **Counters.**
  - op_cnt increments on each DONE→IDLE transition.
  - fix_cnt increments on that same transition only if the transaction passed through FIX.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment.
- **Stability.** sum and err_flag hold stable while out_valid=1 and out_ready=0.
- **Reset.** Asynchronous reset in any state aborts the transaction with no output. After reset:
  - state=IDLE, in_ready=1, out_valid=0.
  - sum=0, err_flag=0, op_cnt=0, fix_cnt=0.

## Timing
- Accept edge = k.
- No-fix path: out_valid is high from edge k+1.
- Fix path: out_valid is high from edge k+2.
- Results are accepted on the first edge with out_valid & out_ready. in_ready rises from the following edge.
- Minimum initiation interval: 3 cycles (no fix, out_ready held high), 4 with fix.
- in_ready=0 in EVAL, FIX and DONE. in_valid is ignored there, and a and b may change freely.
- Counter increments are visible from the edge after the handshake.

## Structure
- **Shared package `rap_pkg`:**
  - state enum (IDLE/EVAL/FIX/DONE)
  - mode encodings (MODE_APPROX, MODE_CORRECT, MODE_EXACT)
  - width constant 16
- **Sub-module `rap_err_det`:** natural split. Purely combinational, 16-bit a/b in, det out, reusable for other rapNN_k variants.
- **Adder instances:** one `rap16_2` instance. The exact adder is a plain 17-bit `+` inside the controller.

## Test plan
- **Exact-clean operands:** mode=01, a=0x0001, b=0x0002, out_ready=1 → sum=0x00003, err_flag=0, out_valid at k+1, fix_cnt unchanged, op_cnt=1.
- **Correction path:** mode=01, a=0x00FF, b=0x0001 → det fires, FIX taken, sum=0x00100 at k+2, err_flag=0, fix_cnt=1.
- **Approx-only mode:** mode=00, a=0x00FF, b=0x0001 → sum=0x000F0, err_flag=1 at k+1, fix_cnt unchanged.
- **Full generate, always-exact mode:**
  - mode=10, a=b=0xFFFF → sum=0x1FFFE at k+2, fix_cnt increments.
  - Same operands with mode=01 → same sum at k+1.
- **Backpressure:** out_ready=0 for 5 cycles after out_valid → sum and err_flag stable, in_ready=0, in_valid pulses ignored. op_cnt increments only after out_ready=1.
- **Reset mid-FIX, then saturation:**
  - Assert rst during FIX → outputs at reset values immediately. A new transaction then completes normally.
  - Force op_cnt to 0xFFFF via 65535 transactions (or a bench with CW=4 and 15 transactions) → stays saturated. cnt_clr → 0.
